// File: rtl/address_sequencer.sv
// Memory address register with load, stride step, signed offset add and a
// return-address stack for call/return; reports overflow, stack status and faults.
module address_sequencer #(
  parameter int unsigned AW         = 6,
  parameter int unsigned STRIDE     = 1,
  parameter int unsigned DEPTH      = 4,
  parameter bit          WRAP_MODE  = 1'b1,
  parameter int unsigned RESET_ADDR = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    op,
  input  logic [AW-1:0] in,
  input  logic [AW-1:0] offset,
  input  logic          clr_flags,
  output logic [AW-1:0] out,
  output logic          valid,
  output logic          ovf,
  output logic          full,
  output logic          empty,
  output logic          fault
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_INC  = 3'b010;
  localparam logic [2:0] OP_DEC  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_CALL = 3'b101;
  localparam logic [2:0] OP_RET  = 3'b110;
  localparam logic [2:0] OP_RSV  = 3'b111;

  localparam logic [AW-1:0]        RST_A = AW'(RESET_ADDR);
  localparam logic signed [AW+1:0] STEP  = (AW+2)'(STRIDE);
  localparam logic signed [AW+1:0] MAXV  = {2'b00, {AW{1'b1}}};
  localparam logic [CW-1:0]        FULLC = CW'(DEPTH);

  logic [AW-1:0]        stack [DEPTH];
  logic [CW-1:0]        count;
  logic [IW-1:0]        widx, ridx;
  logic signed [AW+1:0] base, sext, res;
  logic                 arith;
  logic [AW-1:0]        nxt_out;
  logic                 nxt_valid, fault_n, ovf_set, push, pop;

  assign full  = (count == FULLC);
  assign empty = (count == '0);
  assign widx  = IW'(count);
  assign ridx  = IW'(count - 1'b1);

  // Two guard bits: enough headroom for unsigned stride and signed offset alike.
  always_comb begin
    base      = $signed({2'b00, out});
    sext      = $signed({{2{offset[AW-1]}}, offset});
    res       = base;
    arith     = 1'b0;
    nxt_out   = out;
    nxt_valid = valid;
    fault_n   = 1'b0;
    ovf_set   = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    case (op)
      OP_HOLD: ;
      OP_LOAD: begin
        nxt_out   = in;
        nxt_valid = 1'b1;
      end
      OP_INC: begin
        res   = base + STEP;
        arith = 1'b1;
      end
      OP_DEC: begin
        res   = base - STEP;
        arith = 1'b1;
      end
      OP_ADD: begin
        res   = base + sext;
        arith = 1'b1;
      end
      OP_CALL: begin
        if (full) begin
          fault_n = 1'b1;
        end else begin
          push      = 1'b1;
          nxt_out   = in;
          nxt_valid = 1'b1;
        end
      end
      OP_RET: begin
        if (empty) begin
          fault_n = 1'b1;
        end else begin
          pop       = 1'b1;
          nxt_out   = stack[ridx];
          nxt_valid = 1'b1;
        end
      end
      OP_RSV:  fault_n = 1'b1;
      default: ;
    endcase
    if (arith) begin
      if (res < 0) begin
        ovf_set = 1'b1;
        nxt_out = WRAP_MODE ? res[AW-1:0] : '0;
      end else if (res > MAXV) begin
        ovf_set = 1'b1;
        nxt_out = WRAP_MODE ? res[AW-1:0] : '1;
      end else begin
        nxt_out = res[AW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out   <= RST_A;
      valid <= 1'b0;
      ovf   <= 1'b0;
      fault <= 1'b0;
      count <= '0;
    end else begin
      out   <= nxt_out;
      valid <= nxt_valid;
      fault <= fault_n;
      ovf   <= ovf_set | (ovf & ~clr_flags);
      if (push)
        count <= count + 1'b1;
      else if (pop)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst)
      stack[widx] <= out;
  end

endmodule

// File: tb/tb_address_sequencer.sv
// Directed bench for address_sequencer: a wrapping and a saturating instance
// share stimulus; each scenario task checks hand-computed expectations.
module tb_address_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] op = 3'b000;
  logic [5:0] in = '0;
  logic [5:0] offset = '0;
  logic       clr_flags = 1'b0;

  logic [5:0] w_out, s_out;
  logic w_valid, w_ovf, w_full, w_empty, w_fault;
  logic s_valid, s_ovf, s_full, s_empty, s_fault;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, INC = 3'b010, DEC = 3'b011;
  localparam logic [2:0] ADD = 3'b100, CALL = 3'b101, RET = 3'b110, RSV = 3'b111;

  always #5 clk = ~clk;

  address_sequencer #(.AW(6), .STRIDE(1), .DEPTH(4), .WRAP_MODE(1'b1), .RESET_ADDR(0)) u_wrap (
    .clk(clk), .rst(rst), .op(op), .in(in), .offset(offset), .clr_flags(clr_flags),
    .out(w_out), .valid(w_valid), .ovf(w_ovf), .full(w_full), .empty(w_empty), .fault(w_fault)
  );

  address_sequencer #(.AW(6), .STRIDE(1), .DEPTH(4), .WRAP_MODE(1'b0), .RESET_ADDR(0)) u_sat (
    .clk(clk), .rst(rst), .op(op), .in(in), .offset(offset), .clr_flags(clr_flags),
    .out(s_out), .valid(s_valid), .ovf(s_ovf), .full(s_full), .empty(s_empty), .fault(s_fault)
  );

  task automatic step(input logic [2:0] o, input logic [5:0] i, input logic [5:0] off,
                      input logic c, input logic r);
    op = o; in = i; offset = off; clr_flags = c; rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    step(HOLD, 6'd0, 6'd0, 1'b0, 1'b1);
    checks++; if (w_out !== 6'd0) begin errors++; $display("FAIL reset_out got=%0d exp=0", w_out); end
    checks++; if (w_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", w_valid); end
    checks++; if (w_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", w_ovf); end
    checks++; if (w_empty !== 1'b1 || w_full !== 1'b0) begin errors++; $display("FAIL reset_stack empty=%b full=%b exp 1/0", w_empty, w_full); end
    checks++; if (w_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b exp=0", w_fault); end
    checks++; if (s_out !== 6'd0 || s_valid !== 1'b0 || s_empty !== 1'b1) begin errors++; $display("FAIL reset_sat out=%0d valid=%b empty=%b exp 0/0/1", s_out, s_valid, s_empty); end
    for (int k = 0; k < 5; k++) begin
      step(HOLD, 6'd33, 6'd17, 1'b0, 1'b0);
      checks++;
      if (w_out !== 6'd0 || w_valid !== 1'b0 || w_ovf !== 1'b0 || w_empty !== 1'b1 || w_full !== 1'b0 || w_fault !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d out=%0d valid=%b ovf=%b empty=%b full=%b fault=%b exp 0/0/0/1/0/0",
                 k, w_out, w_valid, w_ovf, w_empty, w_full, w_fault);
      end
    end
  endtask

  task automatic test_wrap;
    step(LOAD, 6'd62, 6'd0, 1'b0, 1'b0);
    checks++; if (w_out !== 6'd62 || w_valid !== 1'b1) begin errors++; $display("FAIL wrap_load out=%0d valid=%b exp 62/1", w_out, w_valid); end
    step(INC, 6'd0, 6'd0, 1'b0, 1'b0);
    checks++; if (w_out !== 6'd63 || w_ovf !== 1'b0) begin errors++; $display("FAIL wrap_inc1 out=%0d ovf=%b exp 63/0", w_out, w_ovf); end
    step(INC, 6'd0, 6'd0, 1'b0, 1'b0);
    checks++; if (w_out !== 6'd0 || w_ovf !== 1'b1) begin errors++; $display("FAIL wrap_inc2 out=%0d ovf=%b exp 0/1", w_out, w_ovf); end
    step(HOLD, 6'd0, 6'd0, 1'b0, 1'b0);
    checks++; if (w_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", w_ovf); end
    step(HOLD, 6'd0, 6'd0, 1'b1, 1'b0);
    checks++; if (w_ovf !== 1'b0 || w_out !== 6'd0) begin errors++; $display("FAIL wrap_clr ovf=%b out=%0d exp 0/0", w_ovf, w_out); end
    step(DEC, 6'd0, 6'd0, 1'b0, 1'b0);
    checks++; if (w_out !== 6'd63 || w_ovf !== 1'b1) begin errors++; $display("FAIL wrap_dec out=%0d ovf=%b exp 63/1", w_out, w_ovf); end
    step(HOLD, 6'd0, 6'd0, 1'b1, 1'b0);
    step(ADD, 6'd0, 6'b110000, 1'b0, 1'b0);
    checks++; if (w_out !== 6'd47 || w_ovf !== 1'b0) begin errors++; $display("FAIL wrap_addneg out=%0d ovf=%b exp 47/0", w_out, w_ovf); end
    step(ADD, 6'd0, 6'd20, 1'b0, 1'b0);
    checks++; if (w_out !== 6'd3 || w_ovf !== 1'b1) begin errors++; $display("FAIL wrap_addpos out=%0d ovf=%b exp 3/1", w_out, w_ovf); end
    step(HOLD, 6'd0, 6'd0, 1'b1, 1'b0);
  endtask

  task automatic test_saturate;
    step(LOAD, 6'd1, 6'd0, 1'b0, 1'b0);
    step(DEC, 6'd0, 6'd0, 1'b0, 1'b0);
    checks++; if (s_out !== 6'd0 || s_ovf !== 1'b0) begin errors++; $display("FAIL sat_dec1 out=%0d ovf=%b exp 0/0", s_out, s_ovf); end
    step(DEC, 6'd0, 6'd0, 1'b0, 1'b0);
    checks++; if (s_out !== 6'd0 || s_ovf !== 1'b1) begin errors++; $display("FAIL sat_dec2 out=%0d ovf=%b exp 0/1", s_out, s_ovf); end
    step(HOLD, 6'd0, 6'd0, 1'b1, 1'b0);
    step(LOAD, 6'd60, 6'd0, 1'b0, 1'b0);
    step(ADD, 6'd0, 6'd10, 1'b0, 1'b0);
    checks++; if (s_out !== 6'd63 || s_ovf !== 1'b1) begin errors++; $display("FAIL sat_addhi out=%0d ovf=%b exp 63/1", s_out, s_ovf); end
    step(ADD, 6'd0, 6'b110000, 1'b1, 1'b0);
    checks++; if (s_out !== 6'd47 || s_ovf !== 1'b0) begin errors++; $display("FAIL sat_addneg out=%0d ovf=%b exp 47/0", s_out, s_ovf); end
    step(ADD, 6'd0, 6'b100000, 1'b0, 1'b0);
    checks++; if (s_out !== 6'd15 || s_ovf !== 1'b0) begin errors++; $display("FAIL sat_addmin out=%0d ovf=%b exp 15/0", s_out, s_ovf); end
    step(HOLD, 6'd0, 6'd0, 1'b1, 1'b0);
  endtask

  task automatic test_stack;
    logic [5:0] calls [4];
    logic [5:0] rets [4];
    calls = '{6'd10, 6'd20, 6'd30, 6'd40};
    rets  = '{6'd30, 6'd20, 6'd10, 6'd5};
    step(LOAD, 6'd5, 6'd0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(CALL, calls[k], 6'd0, 1'b0, 1'b0);
      checks++;
      if (w_out !== calls[k] || w_full !== (k == 3) || w_empty !== 1'b0 || w_fault !== 1'b0) begin
        errors++;
        $display("FAIL call_%0d out=%0d full=%b empty=%b fault=%b exp %0d/%b/0/0", k, w_out, w_full, w_empty, w_fault, calls[k], k == 3);
      end
    end
    step(CALL, 6'd50, 6'd0, 1'b0, 1'b0);
    checks++; if (w_fault !== 1'b1 || w_out !== 6'd40 || w_full !== 1'b1) begin errors++; $display("FAIL call_full fault=%b out=%0d full=%b exp 1/40/1", w_fault, w_out, w_full); end
    step(HOLD, 6'd0, 6'd0, 1'b0, 1'b0);
    checks++; if (w_fault !== 1'b0) begin errors++; $display("FAIL call_fault_pulse got=%b exp=0", w_fault); end
    for (int k = 0; k < 4; k++) begin
      step(RET, 6'd0, 6'd0, 1'b0, 1'b0);
      checks++;
      if (w_out !== rets[k] || w_valid !== 1'b1 || w_empty !== (k == 3) || w_full !== 1'b0) begin
        errors++;
        $display("FAIL ret_%0d out=%0d valid=%b empty=%b full=%b exp %0d/1/%b/0", k, w_out, w_valid, w_empty, w_full, rets[k], k == 3);
      end
    end
    step(RET, 6'd0, 6'd0, 1'b0, 1'b0);
    checks++; if (w_fault !== 1'b1 || w_out !== 6'd5 || w_empty !== 1'b1) begin errors++; $display("FAIL ret_empty fault=%b out=%0d empty=%b exp 1/5/1", w_fault, w_out, w_empty); end
    step(HOLD, 6'd0, 6'd0, 1'b0, 1'b0);
    checks++; if (w_fault !== 1'b0) begin errors++; $display("FAIL ret_fault_pulse got=%b exp=0", w_fault); end
  endtask

  task automatic test_simultaneous;
    step(LOAD, 6'd63, 6'd0, 1'b1, 1'b0);
    checks++; if (w_ovf !== 1'b0) begin errors++; $display("FAIL simul_pre ovf=%b exp=0", w_ovf); end
    step(INC, 6'd0, 6'd0, 1'b1, 1'b0);
    checks++; if (w_out !== 6'd0 || w_ovf !== 1'b1) begin errors++; $display("FAIL set_wins out=%0d ovf=%b exp 0/1", w_out, w_ovf); end
    checks++; if (s_out !== 6'd63 || s_ovf !== 1'b1) begin errors++; $display("FAIL sat_inc out=%0d ovf=%b exp 63/1", s_out, s_ovf); end
    step(HOLD, 6'd0, 6'd0, 1'b1, 1'b0);
    step(RSV, 6'd9, 6'd9, 1'b0, 1'b0);
    checks++; if (w_fault !== 1'b1 || w_out !== 6'd0 || w_valid !== 1'b1) begin errors++; $display("FAIL rsv fault=%b out=%0d valid=%b exp 1/0/1", w_fault, w_out, w_valid); end
    step(HOLD, 6'd0, 6'd0, 1'b0, 1'b0);
    checks++; if (w_fault !== 1'b0 || w_out !== 6'd0) begin errors++; $display("FAIL rsv_pulse fault=%b out=%0d exp 0/0", w_fault, w_out); end
  endtask

  task automatic test_reset_mid;
    step(LOAD, 6'd7, 6'd0, 1'b0, 1'b0);
    step(CALL, 6'd1, 6'd0, 1'b0, 1'b0);
    step(CALL, 6'd2, 6'd0, 1'b0, 1'b0);
    step(RET, 6'd0, 6'd0, 1'b0, 1'b1);
    checks++;
    if (w_out !== 6'd0 || w_empty !== 1'b1 || w_valid !== 1'b0 || w_fault !== 1'b0 || w_full !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid out=%0d empty=%b valid=%b fault=%b full=%b exp 0/1/0/0/0", w_out, w_empty, w_valid, w_fault, w_full);
    end
    step(RET, 6'd0, 6'd0, 1'b0, 1'b0);
    checks++; if (w_fault !== 1'b1 || w_out !== 6'd0 || w_valid !== 1'b0) begin errors++; $display("FAIL ret_after_reset fault=%b out=%0d valid=%b exp 1/0/0", w_fault, w_out, w_valid); end
    step(INC, 6'd0, 6'd0, 1'b0, 1'b0);
    checks++; if (w_out !== 6'd1 || w_valid !== 1'b0 || w_fault !== 1'b0) begin errors++; $display("FAIL inc_invalid out=%0d valid=%b fault=%b exp 1/0/0", w_out, w_valid, w_fault); end
  endtask

  initial begin
    #2;
    test_reset();
    test_wrap();
    test_saturate();
    test_stack();
    test_simultaneous();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
